// File: rtl/kws_layer_sequencer_if.sv
// Signal bundle between the KWS layer sequencer and its surroundings:
// run control, per-stage start/done and PSRAM buses, and the muxed PSRAM pads.
interface kws_layer_sequencer_if #(
  parameter int NUM_LAYERS = 6,
  parameter int LAYER_W    = 3
) ();
  logic                    start;
  logic                    abort;
  logic                    cont_mode;
  logic                    feat_valid;
  logic [NUM_LAYERS-1:0]   layer_start;
  logic [NUM_LAYERS-1:0]   layer_done;
  logic [NUM_LAYERS-1:0]   layer_sck;
  logic [NUM_LAYERS-1:0]   layer_ce_n;
  logic [4*NUM_LAYERS-1:0] layer_douten;
  logic [4*NUM_LAYERS-1:0] layer_dout;
  logic                    psram_sck;
  logic                    psram_ce_n;
  logic [3:0]              psram_douten;
  logic [3:0]              psram_dout;
  logic                    busy;
  logic [LAYER_W-1:0]      cur_layer;
  logic                    done;
  logic                    error;
  logic [LAYER_W-1:0]      err_layer;

  modport master (
    output start, abort, cont_mode, feat_valid,
    output layer_done, layer_sck, layer_ce_n, layer_douten, layer_dout,
    input  layer_start, psram_sck, psram_ce_n, psram_douten, psram_dout,
    input  busy, cur_layer, done, error, err_layer
  );

  modport slave (
    input  start, abort, cont_mode, feat_valid,
    input  layer_done, layer_sck, layer_ce_n, layer_douten, layer_dout,
    output layer_start, psram_sck, psram_ce_n, psram_douten, psram_dout,
    output busy, cur_layer, done, error, err_layer
  );
endinterface

// File: rtl/kws_layer_sequencer.sv
// Steps the KWS accelerator stages one at a time, grants the PSRAM bus to the
// active stage, parks the bus between owners and guards each stage with a watchdog.
module kws_layer_sequencer #(
  parameter int NUM_LAYERS = 6,
  parameter int LAYER_W    = 3,
  parameter int TIMEOUT    = 2**20,
  parameter int TO_W       = 21,
  parameter int GAP_CYCLES = 2
) (
  input logic                  clk,
  input logic                  rst,
  kws_layer_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_FEAT, S_RUN, S_GAP, S_DONE, S_ERR
  } state_t;

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0]   GAP_LAST   = GAP_W'(GAP_CYCLES - 1);
  localparam logic [TO_W-1:0]    TO_LAST    = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [LAYER_W-1:0] LAYER_LAST = LAYER_W'(NUM_LAYERS - 1);

  state_t                state_q, state_d;
  logic [LAYER_W-1:0]    cur_layer_q, cur_layer_d;
  logic [NUM_LAYERS-1:0] layer_start_q, layer_start_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
  logic [LAYER_W-1:0]    err_layer_q, err_layer_d;
  logic [TO_W-1:0]       wd_q, wd_d;
  logic [GAP_W-1:0]      gap_q, gap_d;

  logic       cur_done;
  logic       wd_expired;
  logic       sck_mux;
  logic       ce_n_mux;
  logic [3:0] douten_mux;
  logic [3:0] dout_mux;

  // Bus and done selection from the registered layer index; parked outside RUN.
  always_comb begin
    cur_done   = 1'b0;
    sck_mux    = 1'b0;
    ce_n_mux   = 1'b1;
    douten_mux = 4'h0;
    dout_mux   = 4'h0;
    for (int j = 0; j < NUM_LAYERS; j++) begin
      if (cur_layer_q == LAYER_W'(j)) begin
        cur_done = bus.layer_done[j];
        if (state_q == S_RUN) begin
          sck_mux    = bus.layer_sck[j];
          ce_n_mux   = bus.layer_ce_n[j];
          douten_mux = bus.layer_douten[4*j +: 4];
          dout_mux   = bus.layer_dout[4*j +: 4];
        end
      end
    end
  end

  assign wd_expired = (TIMEOUT != 0) && (wd_q == TO_LAST);

  always_comb begin
    state_d       = state_q;
    cur_layer_d   = cur_layer_q;
    layer_start_d = '0;
    done_d        = 1'b0;
    error_d       = error_q;
    err_layer_d   = err_layer_q;
    wd_d          = wd_q;
    gap_d         = gap_q;
    if (bus.abort) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.start) state_d = S_WAIT_FEAT;
        end
        S_WAIT_FEAT: begin
          if (bus.feat_valid) begin
            state_d       = S_RUN;
            cur_layer_d   = '0;
            layer_start_d = NUM_LAYERS'(1);
            wd_d          = '0;
          end
        end
        S_RUN: begin
          // A done arriving on the watchdog's last cycle still counts as success.
          if (cur_done) begin
            if (cur_layer_q == LAYER_LAST) begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end else begin
              state_d = S_GAP;
              gap_d   = '0;
            end
          end else if (wd_expired) begin
            state_d     = S_ERR;
            error_d     = 1'b1;
            err_layer_d = cur_layer_q;
          end else begin
            wd_d = wd_q + TO_W'(1);
          end
        end
        S_GAP: begin
          if (gap_q == GAP_LAST) begin
            state_d       = S_RUN;
            cur_layer_d   = cur_layer_q + LAYER_W'(1);
            layer_start_d = NUM_LAYERS'(1) << (cur_layer_q + LAYER_W'(1));
            wd_d          = '0;
          end else begin
            gap_d = gap_q + GAP_W'(1);
          end
        end
        S_DONE: begin
          state_d = bus.cont_mode ? S_WAIT_FEAT : S_IDLE;
        end
        S_ERR: begin
          if (bus.start) begin
            state_d     = S_WAIT_FEAT;
            error_d     = 1'b0;
            err_layer_d = '0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cur_layer_q   <= '0;
      layer_start_q <= '0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
      err_layer_q   <= '0;
      wd_q          <= '0;
      gap_q         <= '0;
    end else begin
      state_q       <= state_d;
      cur_layer_q   <= cur_layer_d;
      layer_start_q <= layer_start_d;
      done_q        <= done_d;
      error_q       <= error_d;
      err_layer_q   <= err_layer_d;
      wd_q          <= wd_d;
      gap_q         <= gap_d;
    end
  end

  assign bus.layer_start  = layer_start_q;
  assign bus.psram_sck    = sck_mux;
  assign bus.psram_ce_n   = ce_n_mux;
  assign bus.psram_douten = douten_mux;
  assign bus.psram_dout   = dout_mux;
  assign bus.busy         = (state_q != S_IDLE) && (state_q != S_ERR);
  assign bus.cur_layer    = cur_layer_q;
  assign bus.done         = done_q;
  assign bus.error        = error_q;
  assign bus.err_layer    = err_layer_q;

endmodule

// File: tb/tb_kws_layer_sequencer.sv
// Directed bench for kws_layer_sequencer: sequencing, bus muxing, watchdog,
// abort, continuous mode and reset, with hand-computed expectations.
module tb_kws_layer_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   done_cnt = 0;
  int   n_asserts = 0;
  int   n_fail = 0;

  logic [5:0] sck_tab  = 6'b101100;
  logic [5:0] ce_n_tab = 6'b010011;
  int         t_prev;
  int         base;
  logic       saw_start;

  kws_layer_sequencer_if #(.NUM_LAYERS(6), .LAYER_W(3)) bif ();

  kws_layer_sequencer #(
    .NUM_LAYERS(6), .LAYER_W(3), .TIMEOUT(16), .TO_W(5), .GAP_CYCLES(2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (bif.done === 1'b1) done_cnt <= done_cnt + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_asserts++;
    assert (observed === expected) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic checkParked(input string tag);
    checkOutput({tag, "_sck"},    32'(bif.psram_sck),    32'd0);
    checkOutput({tag, "_ce_n"},   32'(bif.psram_ce_n),   32'd1);
    checkOutput({tag, "_douten"}, 32'(bif.psram_douten), 32'd0);
    checkOutput({tag, "_dout"},   32'(bif.psram_dout),   32'd0);
  endtask

  task automatic applyStimulus(input logic s, input logic fv);
    bif.start      = s;
    bif.feat_valid = fv;
    tick();
    bif.start      = 1'b0;
    bif.feat_valid = 1'b0;
  endtask

  // Enters RUN(0) from IDLE: start, then feat_valid.
  task automatic startRun();
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1);
  endtask

  // Called on the first RUN cycle of layer i; finishes it immediately and,
  // unless last, returns on the first RUN cycle of layer i+1.
  task automatic doLayerFast(input int i);
    checkOutput($sformatf("fast_start%0d", i), 32'(bif.layer_start), 32'(6'd1 << i));
    bif.layer_done = 6'(1) << i;
    tick();
    bif.layer_done = '0;
    if (i < 5) repeat (2) tick();
  endtask

  initial begin
    bif.start        = 1'b0;
    bif.abort        = 1'b0;
    bif.cont_mode    = 1'b0;
    bif.feat_valid   = 1'b0;
    bif.layer_done   = '0;
    bif.layer_sck    = sck_tab;
    bif.layer_ce_n   = ce_n_tab;
    for (int i = 0; i < 6; i++) begin
      bif.layer_douten[4*i +: 4] = 4'(i + 1);
      bif.layer_dout[4*i +: 4]   = 4'(9 + i);
    end

    // Reset state
    repeat (2) tick();
    rst = 1'b0;
    checkOutput("rst_layer_start", 32'(bif.layer_start), 32'd0);
    checkOutput("rst_cur_layer",   32'(bif.cur_layer),   32'd0);
    checkOutput("rst_done",        32'(bif.done),        32'd0);
    checkOutput("rst_busy",        32'(bif.busy),        32'd0);
    checkOutput("rst_error",       32'(bif.error),       32'd0);
    checkOutput("rst_err_layer",   32'(bif.err_layer),   32'd0);
    checkParked("rst_bus");

    // Full six-layer run, each stage done 10 cycles after its start pulse
    $display("[TB] full run");
    applyStimulus(1'b1, 1'b0);
    checkOutput("wait_busy", 32'(bif.busy), 32'd1);
    checkOutput("wait_no_start", 32'(bif.layer_start), 32'd0);
    applyStimulus(1'b0, 1'b1);
    base = done_cnt;
    t_prev = 0;
    for (int i = 0; i < 6; i++) begin
      checkOutput($sformatf("start_pulse%0d", i), 32'(bif.layer_start), 32'(6'd1 << i));
      checkOutput($sformatf("cur_layer%0d", i),   32'(bif.cur_layer),   32'(i));
      if (i > 0) checkOutput($sformatf("spacing%0d", i), 32'(cyc - t_prev), 32'd13);
      t_prev = cyc;
      checkOutput($sformatf("bus_sck%0d", i),    32'(bif.psram_sck),    32'(sck_tab[i]));
      checkOutput($sformatf("bus_ce_n%0d", i),   32'(bif.psram_ce_n),   32'(ce_n_tab[i]));
      checkOutput($sformatf("bus_douten%0d", i), 32'(bif.psram_douten), 32'(i + 1));
      checkOutput($sformatf("bus_dout%0d", i),   32'(bif.psram_dout),   32'(9 + i));
      tick();
      checkOutput($sformatf("pulse_len%0d", i), 32'(bif.layer_start), 32'd0);
      repeat (4) tick();
      if (i == 2) begin
        bif.layer_done = 6'b010000;
        tick();
        bif.layer_done = '0;
        repeat (4) tick();
        checkOutput("spurious_cur_layer", 32'(bif.cur_layer),  32'd2);
        checkOutput("spurious_sck",       32'(bif.psram_sck),  32'd1);
        checkOutput("spurious_ce_n",      32'(bif.psram_ce_n), 32'd0);
      end else begin
        repeat (5) tick();
      end
      bif.layer_done = 6'(1) << i;
      tick();
      bif.layer_done = '0;
      if (i < 5) begin
        checkParked($sformatf("gap%0d", i));
        checkOutput($sformatf("gap_busy%0d", i), 32'(bif.busy), 32'd1);
        repeat (2) tick();
      end else begin
        checkOutput("done_pulse", 32'(bif.done), 32'd1);
        checkOutput("done_busy",  32'(bif.busy), 32'd1);
        tick();
        checkOutput("done_len",  32'(bif.done), 32'd0);
        checkOutput("idle_busy", 32'(bif.busy), 32'd0);
        checkParked("idle_bus");
      end
    end
    checkOutput("done_count_run1", 32'(done_cnt - base), 32'd1);

    // Watchdog: stage 3 never finishes
    $display("[TB] watchdog");
    startRun();
    for (int i = 0; i < 3; i++) doLayerFast(i);
    checkOutput("to_start3", 32'(bif.layer_start), 32'b001000);
    checkOutput("to_run_sck", 32'(bif.psram_sck), 32'd1);
    repeat (15) tick();
    checkOutput("to_edge_error", 32'(bif.error), 32'd0);
    checkOutput("to_edge_busy",  32'(bif.busy),  32'd1);
    tick();
    checkOutput("to_error",       32'(bif.error),       32'd1);
    checkOutput("to_err_layer",   32'(bif.err_layer),   32'd3);
    checkOutput("to_busy",        32'(bif.busy),        32'd0);
    checkOutput("to_layer_start", 32'(bif.layer_start), 32'd0);
    checkParked("to_bus");
    tick();
    checkOutput("to_sticky", 32'(bif.error), 32'd1);
    applyStimulus(1'b1, 1'b0);
    checkOutput("to_clr_error", 32'(bif.error),     32'd0);
    checkOutput("to_clr_layer", 32'(bif.err_layer), 32'd0);
    checkOutput("to_rearm_busy", 32'(bif.busy),     32'd1);
    bif.abort = 1'b1;
    tick();
    bif.abort = 1'b0;
    checkOutput("abort_wait_busy", 32'(bif.busy), 32'd0);

    // Abort colliding with the final layer_done, then abort during GAP
    $display("[TB] abort");
    base = done_cnt;
    startRun();
    for (int i = 0; i < 5; i++) doLayerFast(i);
    bif.abort      = 1'b1;
    bif.layer_done = 6'b100000;
    tick();
    bif.abort      = 1'b0;
    bif.layer_done = '0;
    checkOutput("abort_done",  32'(bif.done), 32'd0);
    checkOutput("abort_busy",  32'(bif.busy), 32'd0);
    checkParked("abort_bus");
    tick();
    checkOutput("abort_no_done", 32'(done_cnt - base), 32'd0);
    startRun();
    bif.layer_done = 6'b000001;
    tick();
    bif.layer_done = '0;
    bif.abort = 1'b1;
    tick();
    bif.abort = 1'b0;
    saw_start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (bif.layer_start != 6'd0) saw_start = 1'b1;
      tick();
    end
    checkOutput("abort_gap_start", 32'(saw_start), 32'd0);
    checkOutput("abort_gap_busy",  32'(bif.busy),  32'd0);

    // Continuous mode: two utterances, one start
    $display("[TB] continuous mode");
    bif.cont_mode = 1'b1;
    base = done_cnt;
    startRun();
    for (int i = 0; i < 6; i++) doLayerFast(i);
    checkOutput("cont_done1", 32'(bif.done), 32'd1);
    tick();
    checkOutput("cont_rearm_busy", 32'(bif.busy), 32'd1);
    repeat (3) tick();
    checkOutput("cont_idle_start", 32'(bif.layer_start), 32'd0);
    applyStimulus(1'b0, 1'b1);
    for (int i = 0; i < 6; i++) doLayerFast(i);
    checkOutput("cont_done2", 32'(bif.done), 32'd1);
    tick();
    checkOutput("cont_rearm2_busy", 32'(bif.busy), 32'd1);
    checkOutput("cont_done_count", 32'(done_cnt - base), 32'd2);
    bif.cont_mode = 1'b0;
    bif.abort = 1'b1;
    tick();
    bif.abort = 1'b0;

    // Reset mid-RUN(4)
    $display("[TB] reset mid-run");
    startRun();
    for (int i = 0; i < 4; i++) doLayerFast(i);
    tick();
    checkOutput("pre_rst_cur", 32'(bif.cur_layer), 32'd4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("mid_rst_cur",   32'(bif.cur_layer),   32'd0);
    checkOutput("mid_rst_busy",  32'(bif.busy),        32'd0);
    checkOutput("mid_rst_start", 32'(bif.layer_start), 32'd0);
    checkOutput("mid_rst_done",  32'(bif.done),        32'd0);
    checkOutput("mid_rst_error", 32'(bif.error),       32'd0);
    checkParked("mid_rst_bus");

    // layer_done on the watchdog's last cycle advances without error
    $display("[TB] timeout boundary");
    startRun();
    repeat (15) tick();
    bif.layer_done = 6'b000001;
    tick();
    bif.layer_done = '0;
    checkOutput("bnd_error", 32'(bif.error), 32'd0);
    checkOutput("bnd_busy",  32'(bif.busy),  32'd1);
    checkParked("bnd_gap");
    repeat (2) tick();
    checkOutput("bnd_next_start", 32'(bif.layer_start), 32'b000010);
    checkOutput("bnd_next_cur",   32'(bif.cur_layer),   32'd1);
    bif.abort = 1'b1;
    tick();
    bif.abort = 1'b0;
    checkOutput("final_busy", 32'(bif.busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
